// File: rtl/float_recip_stream.sv
// Streaming reciprocal: 12-stage restoring-division core behind valid/ready and a credit-gated FIFO.
// Define FLOAT_RECIP_STREAM_SPECIAL_EN to map +-0, +-inf and NaN to IEEE special results.
module float_recip_stream #(
  parameter  int MANTISSA_SIZE = 23,
  parameter  int FIFO_DEPTH    = 16,
  localparam int FLOAT_SIZE    = 9 + MANTISSA_SIZE,
  localparam int CNT_W         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [FLOAT_SIZE-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FLOAT_SIZE-1:0] m_data,
  output logic [CNT_W-1:0]      in_flight
);

  localparam int M       = MANTISSA_SIZE;
  localparam int LATENCY = 12;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int ITER    = M + 2;
  localparam int STEP    = (ITER + LATENCY - 1) / LATENCY;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Up to STEP quotient bits of floor(2^(2M+1) / significand) per stage.
  function automatic logic [M+1:0] div_run(
    input logic [M+1:0] rem,
    input logic [M+1:0] quo,
    input logic [M:0]   dvs,
    input int           first,
    input logic         want_quo
  );
    logic [M+1:0] r;
    logic [M+1:0] q;
    r = rem;
    q = quo;
    for (int j = 0; j < STEP; j++) begin
      if (first + j < ITER) begin
        if ({1'b0, dvs} <= r) begin
          r = r - {1'b0, dvs};
          q = {q[M:0], 1'b1};
        end else begin
          q = {q[M:0], 1'b0};
        end
        r = r << 1;
      end
    end
    return want_quo ? q : r;
  endfunction

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    logic         sg_i;
    logic [7:0]   ex_i;
    logic [M:0]   dv_i;
    logic [M+1:0] rm_i;
    logic [M+1:0] qt_i;
    logic         sgn_q;
    logic [7:0]   exp_q;
    logic [M+1:0] quo_q;

    if (g == 0) begin : g_in
      assign sg_i = s_data[FLOAT_SIZE-1];
      assign ex_i = s_data[FLOAT_SIZE-2 -: 8];
      assign dv_i = {1'b1, s_data[M-1:0]};
      assign rm_i = {2'b01, {M{1'b0}}};
      assign qt_i = '0;
    end else begin : g_mid
      assign sg_i = g_stage[g-1].sgn_q;
      assign ex_i = g_stage[g-1].exp_q;
      assign dv_i = g_stage[g-1].g_rem.dvs_q;
      assign rm_i = g_stage[g-1].g_rem.rem_q;
      assign qt_i = g_stage[g-1].quo_q;
    end

    always_ff @(posedge clk) begin
      sgn_q <= sg_i;
      exp_q <= ex_i;
      quo_q <= div_run(rm_i, qt_i, dv_i, g * STEP, 1'b1);
    end

    if (g < LATENCY - 1) begin : g_rem
      logic [M:0]   dvs_q;
      logic [M+1:0] rem_q;
      always_ff @(posedge clk) begin
        dvs_q <= dv_i;
        rem_q <= div_run(rm_i, qt_i, dv_i, g * STEP, 1'b0);
      end
    end
  end

  logic                  sgn_fin;
  logic [7:0]            exp_fin;
  logic [M+1:0]          quo_fin;
  logic [FLOAT_SIZE-1:0] core_res;

  assign sgn_fin = g_stage[LATENCY-1].sgn_q;
  assign exp_fin = g_stage[LATENCY-1].exp_q;
  assign quo_fin = g_stage[LATENCY-1].quo_q;

  // Quotient is 2^(M+1) only for an exact power-of-two input.
  always_comb begin
    core_res = {sgn_fin, 8'd253 - exp_fin, quo_fin[M-1:0]};
    if (quo_fin[M+1]) begin
      core_res = {sgn_fin, 8'd254 - exp_fin, quo_fin[M:1]};
    end
  end

  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [FLOAT_SIZE-1:0] wdata;
  logic [LATENCY-1:0]    vld_q, vld_d;
  logic [AW:0]           wr_q, wr_d;
  logic [AW:0]           rd_q, rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FLOAT_SIZE-1:0] mem_q [FIFO_DEPTH];

  assign s_ready   = !reset && (cnt_q < DEPTH_C);
  assign accept    = s_valid && s_ready;
  assign push      = vld_q[LATENCY-1];
  assign m_valid   = wr_q != rd_q;
  assign pop       = m_valid && m_ready;
  assign m_data    = mem_q[rd_q[AW-1:0]];
  assign in_flight = cnt_q;

`ifdef FLOAT_RECIP_STREAM_SPECIAL_EN
  logic                  spec_hit;
  logic [FLOAT_SIZE-1:0] spec_val;
  logic [LATENCY-1:0]    spf_q;
  logic [FLOAT_SIZE-1:0] spv_q [LATENCY];

  always_comb begin
    spec_hit = 1'b0;
    spec_val = s_data;
    unique case (1'b1)
      s_data[FLOAT_SIZE-2:0] == '0: begin
        spec_hit = 1'b1;
        spec_val = {s_data[FLOAT_SIZE-1], 8'hFF, {M{1'b0}}};
      end
      s_data[FLOAT_SIZE-2 -: 8] == 8'hFF: begin
        spec_hit = 1'b1;
        if (s_data[M-1:0] == '0) begin
          spec_val = {s_data[FLOAT_SIZE-1], {(FLOAT_SIZE-1){1'b0}}};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    spf_q    <= {spf_q[LATENCY-2:0], accept && spec_hit};
    spv_q[0] <= spec_val;
    for (int i = 1; i < LATENCY; i++) begin
      spv_q[i] <= spv_q[i-1];
    end
  end

  assign wdata = spf_q[LATENCY-1] ? spv_q[LATENCY-1] : core_res;
`else
  assign wdata = core_res;
`endif

  always_comb begin
    vld_d = {vld_q[LATENCY-2:0], accept};
    wr_d  = wr_q + {{AW{1'b0}}, push};
    rd_d  = rd_q + {{AW{1'b0}}, pop};
    cnt_d = cnt_q;
    unique case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: tb/tb_float_recip_stream.sv
// Randomised bench for float_recip_stream against a quotient-based reciprocal model.
module tb_float_recip_stream;

  localparam int LAT   = 12;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [4:0]  in_flight;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          pop_cyc[$];

  float_recip_stream #(
    .MANTISSA_SIZE(23),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .in_flight(in_flight)
  );

  always #5 clk = ~clk;

  // 1/x truncated to 24 significant bits.
  function automatic logic [31:0] ref_recip(input logic [31:0] x);
    logic [31:0]     r;
    longint unsigned sig;
    longint unsigned quo;
    int              e;
    e   = int'(x[30:23]);
    sig = 64'd8388608 + 64'(x[22:0]);
    quo = (64'd1 << 47) / sig;
    if (quo == (64'd1 << 24)) r = {x[31], 8'(254 - e), 23'd0};
    else r = {x[31], 8'(253 - e), 23'(quo - 64'd8388608)};
`ifdef FLOAT_RECIP_STREAM_SPECIAL_EN
    if (x[30:0] == 31'd0) r = {x[31], 8'hFF, 23'd0};
    else if (x[30:23] == 8'hFF) r = (x[22:0] == 23'd0) ? {x[31], 31'd0} : x;
`endif
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    e = 8'($urandom_range(1, 252));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic tick();
    if (s_valid && s_ready) exp_q.push_back(ref_recip(s_data));
    if (m_valid && m_ready) begin
      got_q.push_back(m_data);
      pop_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear();
    exp_q.delete();
    got_q.delete();
    pop_cyc.delete();
  endtask

  task automatic drain(input int n, output bit to);
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 300 && got_q.size() < n; k++) tick();
    to = got_q.size() < n;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h3F800000;
    m_ready = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_m_valid got %b want 0", m_valid);
    end
    n_cmp++;
    if (s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_s_ready got %b want 0", s_ready);
    end
    n_cmp++;
    if (in_flight !== 5'd0) begin
      n_err++;
      $display("FAIL rst_in_flight got %0d want 0", in_flight);
    end
    reset   = 1'b0;
    s_valid = 1'b0;
    tick();
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL post_rst_s_ready got %b want 1", s_ready);
    end
    clear();
  endtask

  task automatic test_single();
    int lat;
    bit to;
    clear();
    s_data  = 32'h3F800000;
    s_valid = 1'b1;
    m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    lat = 1;
    while (!m_valid && lat < 40) begin
      tick();
      lat++;
    end
    n_cmp++;
    if (lat !== LAT + 1) begin
      n_err++;
      $display("FAIL single_latency got %0d want %0d", lat, LAT + 1);
    end
    n_cmp++;
    if (m_data !== 32'h3F800000) begin
      n_err++;
      $display("FAIL single_data got %h want 3f800000", m_data);
    end
    drain(1, to);
    n_cmp++;
    if (to || got_q.size() != 1) begin
      n_err++;
      $display("FAIL single_count got %0d want 1", got_q.size());
    end
  endtask

  task automatic test_stream();
    logic [31:0] vals[100];
    int drops, gaps, sbad, n;
    bit to;
    clear();
    drops = 0;
    vals[0] = 32'hBF800000;
    for (int i = 1; i < 100; i++) vals[i] = rand_op();
    m_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_data  = vals[i];
      s_valid = 1'b1;
      if (!s_ready) drops++;
      tick();
    end
    drain(100, to);
    n_cmp++;
    if (drops !== 0) begin
      n_err++;
      $display("FAIL stream_ready_drops got %0d want 0", drops);
    end
    n_cmp++;
    if (to || got_q.size() != 100) begin
      n_err++;
      $display("FAIL stream_count got %0d want 100", got_q.size());
    end
    n = (got_q.size() < 100) ? got_q.size() : 100;
    sbad = 0;
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (got_q[i] !== ref_recip(vals[i])) begin
        n_err++;
        $display("FAIL stream_data[%0d] got %h want %h", i, got_q[i], ref_recip(vals[i]));
      end
      if (got_q[i][31] !== vals[i][31]) sbad++;
    end
    n_cmp++;
    if (sbad !== 0) begin
      n_err++;
      $display("FAIL stream_sign got %0d bad want 0", sbad);
    end
    n_cmp++;
    if (n == 0 || got_q[0] !== 32'hBF800000) begin
      n_err++;
      $display("FAIL stream_neg_one got %h want bf800000", n ? got_q[0] : 32'h0);
    end
    gaps = 0;
    for (int i = 1; i < n; i++) if (pop_cyc[i] - pop_cyc[i-1] != 1) gaps++;
    n_cmp++;
    if (gaps !== 0) begin
      n_err++;
      $display("FAIL stream_throughput got %0d gaps want 0", gaps);
    end
  endtask

  task automatic test_backpressure();
    int acc;
    bit to;
    clear();
    acc     = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      s_valid = 1'b1;
      s_data  = rand_op();
      if (s_ready) acc++;
      tick();
    end
    s_valid = 1'b0;
    n_cmp++;
    if (acc !== DEPTH) begin
      n_err++;
      $display("FAIL bp_accepts got %0d want %0d", acc, DEPTH);
    end
    n_cmp++;
    if (s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_s_ready got %b want 0", s_ready);
    end
    n_cmp++;
    if (in_flight !== 5'(DEPTH)) begin
      n_err++;
      $display("FAIL bp_in_flight got %0d want %0d", in_flight, DEPTH);
    end
    drain(acc, to);
    n_cmp++;
    if (to || got_q.size() != DEPTH) begin
      n_err++;
      $display("FAIL bp_drain_count got %0d want %0d", got_q.size(), DEPTH);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL bp_data[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bit          prev_stall;
    logic [31:0] prev_data;
    int          credit;
    bit          to;
    clear();
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int c = 0; c < 400; c++) begin
      s_valid = 1'($urandom);
      s_data  = rand_op();
      m_ready = 1'($urandom);
      if (prev_stall) begin
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin
          n_err++;
          $display("FAIL rand_hold c%0d got %b/%h want 1/%h", c, m_valid, m_data, prev_data);
        end
      end
      credit = exp_q.size() - got_q.size();
      n_cmp++;
      if (in_flight !== 5'(credit) || credit > DEPTH) begin
        n_err++;
        $display("FAIL rand_in_flight c%0d got %0d want %0d", c, in_flight, credit);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      tick();
    end
    drain(exp_q.size(), to);
    n_cmp++;
    if (to || got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL rand_data[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int          stale;
    logic [31:0] x;
    bit          to;
    clear();
    m_ready = 1'b0;
    s_valid = 1'b1;
    repeat (3) begin
      s_data = rand_op();
      tick();
    end
    s_valid = 1'b0;
    repeat (LAT + 2) tick();
    s_valid = 1'b1;
    repeat (5) begin
      s_data = rand_op();
      tick();
    end
    s_valid = 1'b0;
    n_cmp++;
    if (in_flight !== 5'd8 || m_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_setup got %0d/%b want 8/1", in_flight, m_valid);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst_m_valid got %b want 0", m_valid);
    end
    n_cmp++;
    if (in_flight !== 5'd0) begin
      n_err++;
      $display("FAIL mid_rst_in_flight got %0d want 0", in_flight);
    end
    reset   = 1'b0;
    m_ready = 1'b1;
    stale   = 0;
    repeat (30) begin
      if (m_valid) stale++;
      tick();
    end
    n_cmp++;
    if (stale !== 0) begin
      n_err++;
      $display("FAIL mid_stale got %0d want 0", stale);
    end
    clear();
    x       = rand_op();
    s_data  = x;
    s_valid = 1'b1;
    tick();
    drain(1, to);
    n_cmp++;
    if (to || got_q.size() != 1 || got_q[0] !== ref_recip(x)) begin
      n_err++;
      $display("FAIL mid_after got %h want %h", got_q.size() ? got_q[0] : 32'h0, ref_recip(x));
    end
  endtask

`ifdef FLOAT_RECIP_STREAM_SPECIAL_EN
  task automatic test_special();
    logic [31:0] xin[4];
    logic [31:0] want[4];
    bit          to;
    clear();
    xin[0] = 32'h00000000; want[0] = 32'h7F800000;
    xin[1] = 32'h80000000; want[1] = 32'hFF800000;
    xin[2] = 32'h7F800000; want[2] = 32'h00000000;
    xin[3] = 32'h7FC00000; want[3] = 32'h7FC00000;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data  = xin[i];
      s_valid = 1'b1;
      tick();
    end
    drain(4, to);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (to || got_q[i] !== want[i]) begin
        n_err++;
        $display("FAIL special[%0d] got %h want %h", i, got_q[i], want[i]);
      end
    end
  endtask
`endif

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef FLOAT_RECIP_STREAM_SPECIAL_EN
    test_special();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
